// File: rtl/camera_world_transformer.sv
// Purpose : camera-space -> world-space triangle transform, p_world = R * p_cam + C (Q16.16).
// Latency : out_valid rises 4 edges after the accepting edge; 1 triangle / 5 cycles back-to-back.
// Backpr. : holds DONE with out_triangle frozen while out_ready=0; in_ready = IDLE | (DONE & out_ready).
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   transform [287:0]   {pos, rot_sin, rot_cos}, each {x,y,z} signed Q16.16
//   triangle  [383:0]   {v0, v1, v2}, each vertex {pos{x,y,z}, color[31:0]}
//   in_valid/in_ready   input handshake
//   out_triangle        world-space triangle, same layout as triangle
//   out_valid/out_ready output handshake
//   busy                high whenever a triangle is in flight
module camera_world_transformer #(
  parameter bit SATURATE = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [287:0] transform,
  input  logic [383:0] triangle,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [383:0] out_triangle,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic signed [31:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t pos;
    vec3_t rot_sin;
    vec3_t rot_cos;
  } transform_t;

  typedef struct packed {
    vec3_t       pos;
    logic [31:0] color;
  } vertex_t;

  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
  } triangle_t;

  typedef enum logic [2:0] {IDLE, MAT, V0, V1, V2, DONE} state_t;

  state_t     state, state_nxt;
  transform_t xf_in, xf_q;
  triangle_t  tri_in, tri_q, out_q;
  logic signed [31:0] r11, r12, r13, r21, r22, r23, r31, r32, r33;
  logic       accept;
  vertex_t    vin, vout;

  assign xf_in        = transform;
  assign tri_in       = triangle;
  assign out_triangle = out_q;

  // Q16.16 multiply: full signed product, arithmetic shift (floor), keep low 32 bits.
  function automatic logic signed [31:0] qmul(input logic signed [31:0] a,
                                              input logic signed [31:0] b);
    return 32'((64'(a) * 64'(b)) >>> 16);
  endfunction

  // Row dot product kept at full precision; only one rounding shift before adding C.
  function automatic logic signed [31:0] rowdot(input logic signed [31:0] a,
                                                input logic signed [31:0] b,
                                                input logic signed [31:0] c,
                                                input vec3_t              p,
                                                input logic signed [31:0] off);
    logic signed [66:0] acc;
    acc = 67'(64'(a) * 64'(p.x)) + 67'(64'(b) * 64'(p.y)) + 67'(64'(c) * 64'(p.z));
    acc = (acc >>> 16) + 67'(off);
    if (SATURATE) begin
      if (acc > 67'sh7FFFFFFF) return 32'sh7FFFFFFF;
      if (acc < -67'sh80000000) return -32'sh80000000;
    end
    return 32'(acc);
  endfunction

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MAT;
      end
      MAT:  state_nxt = V0;
      V0:   state_nxt = V1;
      V1:   state_nxt = V2;
      V2:   state_nxt = DONE;
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_nxt = in_valid ? MAT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Nothing may be accepted while reset is held.
    in_ready = in_ready & rst_n;
  end

  assign accept    = in_valid & in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // One shared vertex datapath; the FSM state selects which latched vertex it sees.
  always_comb begin
    vin = tri_q.v0;
    case (state)
      V1:      vin = tri_q.v1;
      V2:      vin = tri_q.v2;
      default: vin = tri_q.v0;
    endcase
    vout.pos.x = rowdot(r11, r12, r13, vin.pos, xf_q.pos.x);
    vout.pos.y = rowdot(r21, r22, r23, vin.pos, xf_q.pos.y);
    vout.pos.z = rowdot(r31, r32, r33, vin.pos, xf_q.pos.z);
    vout.color = vin.color;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      xf_q  <= '0;
      tri_q <= '0;
      out_q <= '0;
      r11 <= '0; r12 <= '0; r13 <= '0;
      r21 <= '0; r22 <= '0; r23 <= '0;
      r31 <= '0; r32 <= '0; r33 <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        xf_q  <= xf_in;
        tri_q <= tri_in;
      end
      case (state)
        MAT: begin
          // ZYX rotation: x = roll, y = pitch, z = yaw.
          r11 <= qmul(xf_q.rot_cos.z, xf_q.rot_cos.y);
          r12 <= qmul(qmul(xf_q.rot_cos.z, xf_q.rot_sin.y), xf_q.rot_sin.x)
                 - qmul(xf_q.rot_sin.z, xf_q.rot_cos.x);
          r13 <= qmul(qmul(xf_q.rot_cos.z, xf_q.rot_sin.y), xf_q.rot_cos.x)
                 + qmul(xf_q.rot_sin.z, xf_q.rot_sin.x);
          r21 <= qmul(xf_q.rot_sin.z, xf_q.rot_cos.y);
          r22 <= qmul(qmul(xf_q.rot_sin.z, xf_q.rot_sin.y), xf_q.rot_sin.x)
                 + qmul(xf_q.rot_cos.z, xf_q.rot_cos.x);
          r23 <= qmul(qmul(xf_q.rot_sin.z, xf_q.rot_sin.y), xf_q.rot_cos.x)
                 - qmul(xf_q.rot_cos.z, xf_q.rot_sin.x);
          r31 <= -xf_q.rot_sin.y;
          r32 <= qmul(xf_q.rot_cos.y, xf_q.rot_sin.x);
          r33 <= qmul(xf_q.rot_cos.y, xf_q.rot_cos.x);
        end
        V0:      out_q.v0 <= vout;
        V1:      out_q.v1 <= vout;
        V2:      out_q.v2 <= vout;
        default: ;
      endcase
    end
  end

endmodule
